// File: rtl/decode_queue_pkg.sv
// Shared widths, op-id encoding and the decoded record stored per queue entry.
// ILLEGAL_INSTR_EN adds an illegal flag to the record.
package decode_queue_pkg;

    localparam int unsigned InstrWidth   = 32;
    localparam int unsigned InstrIdWidth = 6;
    localparam int unsigned ImmWidth     = 32;
    localparam int unsigned RegIdxWidth  = 5;

    // IdZero doubles as the "unrecognised" marker.
    typedef enum logic [InstrIdWidth-1:0] {
        IdZero,
        IdLui, IdAuipc, IdJal, IdJalr,
        IdBeq, IdBne, IdBlt, IdBge, IdBltu, IdBgeu,
        IdLb, IdLh, IdLw, IdLbu, IdLhu,
        IdSb, IdSh, IdSw,
        IdAddi, IdSlti, IdSltiu, IdXori, IdOri, IdAndi, IdSlli, IdSrli, IdSrai,
        IdAdd, IdSub, IdSll, IdSlt, IdSltu, IdXor, IdSrl, IdSra, IdOr, IdAnd,
        IdFence, IdEcall, IdEbreak
    } instr_id_e;

    typedef struct packed {
        instr_id_e              instr_id;
        logic [ImmWidth-1:0]    imm;
        logic [RegIdxWidth-1:0] rs1;
        logic [RegIdxWidth-1:0] rs2;
        logic [RegIdxWidth-1:0] rd;
`ifdef ILLEGAL_INSTR_EN
        logic                   illegal;
`endif
    } dec_rec_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and dispatch-side handshake bundle of the decode queue.
// illegal_out exists only when ILLEGAL_INSTR_EN is defined.
interface decode_queue_if #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_WIDTH = 32
);
    import decode_queue_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [InstrWidth-1:0]         instr_in;
    logic [PC_WIDTH-1:0]           pc_in;
    logic                          out_valid;
    logic                          out_ready;
    instr_id_e                     instr_id_out;
    logic [ImmWidth-1:0]           imm_out;
    logic [RegIdxWidth-1:0]        rs1_out;
    logic [RegIdxWidth-1:0]        rs2_out;
    logic [RegIdxWidth-1:0]        rd_out;
    logic [PC_WIDTH-1:0]           pc_out;
    logic [$clog2(DEPTH):0]        count_out;
`ifdef ILLEGAL_INSTR_EN
    logic                          illegal_out;
`endif

    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, instr_id_out, imm_out, rs1_out, rs2_out, rd_out, pc_out,
`ifdef ILLEGAL_INSTR_EN
        input  illegal_out,
`endif
        input  count_out
    );

    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, instr_id_out, imm_out, rs1_out, rs2_out, rd_out, pc_out,
`ifdef ILLEGAL_INSTR_EN
        output illegal_out,
`endif
        output count_out
    );

endinterface

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I word -> decoded record (op id, immediate, register indices).
// With ILLEGAL_INSTR_EN the record also flags words that match no RV32I op.
module rv32i_decoder
    import decode_queue_pkg::*;
(
    input  logic [InstrWidth-1:0] instr,
    output dec_rec_t              rec
);

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [ImmWidth-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_sh = {27'b0, instr[24:20]};

    always_comb begin
        rec     = '0;
        rec.rs1 = instr[19:15];
        rec.rs2 = instr[24:20];
        rec.rd  = instr[11:7];
        case (opcode)
            7'b0110111, 7'b0010111: begin
                rec.instr_id = (opcode[5]) ? IdLui : IdAuipc;
                rec.imm      = imm_u;
                rec.rs1      = '0;
                rec.rs2      = '0;
            end
            7'b1101111: begin
                rec.instr_id = IdJal;
                rec.imm      = imm_j;
                rec.rs1      = '0;
                rec.rs2      = '0;
            end
            7'b1100111: begin
                rec.imm = imm_i;
                rec.rs2 = '0;
                if (funct3 == 3'b000) rec.instr_id = IdJalr;
            end
            7'b1100011: begin
                rec.imm = imm_b;
                rec.rd  = '0;
                case (funct3)
                    3'b000:  rec.instr_id = IdBeq;
                    3'b001:  rec.instr_id = IdBne;
                    3'b100:  rec.instr_id = IdBlt;
                    3'b101:  rec.instr_id = IdBge;
                    3'b110:  rec.instr_id = IdBltu;
                    3'b111:  rec.instr_id = IdBgeu;
                    default: rec.instr_id = IdZero;
                endcase
            end
            7'b0000011: begin
                rec.imm = imm_i;
                rec.rs2 = '0;
                case (funct3)
                    3'b000:  rec.instr_id = IdLb;
                    3'b001:  rec.instr_id = IdLh;
                    3'b010:  rec.instr_id = IdLw;
                    3'b100:  rec.instr_id = IdLbu;
                    3'b101:  rec.instr_id = IdLhu;
                    default: rec.instr_id = IdZero;
                endcase
            end
            7'b0100011: begin
                rec.imm = imm_s;
                rec.rd  = '0;
                case (funct3)
                    3'b000:  rec.instr_id = IdSb;
                    3'b001:  rec.instr_id = IdSh;
                    3'b010:  rec.instr_id = IdSw;
                    default: rec.instr_id = IdZero;
                endcase
            end
            7'b0010011: begin
                rec.imm = imm_i;
                rec.rs2 = '0;
                case (funct3)
                    3'b000: rec.instr_id = IdAddi;
                    3'b010: rec.instr_id = IdSlti;
                    3'b011: rec.instr_id = IdSltiu;
                    3'b100: rec.instr_id = IdXori;
                    3'b110: rec.instr_id = IdOri;
                    3'b111: rec.instr_id = IdAndi;
                    3'b001: begin
                        rec.imm = imm_sh;
                        if (funct7 == 7'b0000000) rec.instr_id = IdSlli;
                    end
                    default: begin
                        rec.imm = imm_sh;
                        if (funct7 == 7'b0000000)      rec.instr_id = IdSrli;
                        else if (funct7 == 7'b0100000) rec.instr_id = IdSrai;
                    end
                endcase
            end
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  rec.instr_id = IdAdd;
                        3'b001:  rec.instr_id = IdSll;
                        3'b010:  rec.instr_id = IdSlt;
                        3'b011:  rec.instr_id = IdSltu;
                        3'b100:  rec.instr_id = IdXor;
                        3'b101:  rec.instr_id = IdSrl;
                        3'b110:  rec.instr_id = IdOr;
                        default: rec.instr_id = IdAnd;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      rec.instr_id = IdSub;
                    else if (funct3 == 3'b101) rec.instr_id = IdSra;
                end
            end
            7'b0001111: begin
                rec.imm = imm_i;
                rec.rs2 = '0;
                if (funct3 == 3'b000) rec.instr_id = IdFence;
            end
            7'b1110011: begin
                rec.imm = imm_i;
                rec.rs2 = '0;
                if (instr == 32'h0000_0073)      rec.instr_id = IdEcall;
                else if (instr == 32'h0010_0073) rec.instr_id = IdEbreak;
            end
            default: rec.instr_id = IdZero;
        endcase
`ifdef ILLEGAL_INSTR_EN
        rec.illegal = (rec.instr_id == IdZero);
`endif
    end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: RV32I words are decoded on entry and held in a DEPTH-entry circular FIFO.
// ILLEGAL_INSTR_EN adds a per-entry illegal flag on the dispatch side.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    decode_queue_if.slave bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]     count_q, count_d;
    dec_rec_t            rec_q [DEPTH];
    logic [PC_WIDTH-1:0] pc_q  [DEPTH];
    dec_rec_t            dec_rec;
    dec_rec_t            head_rec;
    logic                enq, deq;

    rv32i_decoder u_decoder (
        .instr (bus.instr_in),
        .rec   (dec_rec)
    );

    // Handshake flags depend only on registered occupancy.
    assign bus.in_ready  = (count_q < CntW'(DEPTH));
    assign bus.out_valid = (count_q != '0);

    assign enq = rdy_in && bus.in_valid && bus.in_ready && !flush_in;
    assign deq = rdy_in && bus.out_valid && bus.out_ready && !flush_in;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in && flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PtrW'(1);
            if (deq) head_d = head_q + PtrW'(1);
            if (enq && !deq)      count_d = count_q + CntW'(1);
            else if (!enq && deq) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rec_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) begin
                rec_q[tail_q] <= dec_rec;
                pc_q[tail_q]  <= bus.pc_in;
            end
        end
    end

    assign head_rec         = rec_q[head_q];
    assign bus.instr_id_out = head_rec.instr_id;
    assign bus.imm_out      = head_rec.imm;
    assign bus.rs1_out      = head_rec.rs1;
    assign bus.rs2_out      = head_rec.rs2;
    assign bus.rd_out       = head_rec.rd;
    assign bus.pc_out       = pc_q[head_q];
    assign bus.count_out    = count_q;
`ifdef ILLEGAL_INSTR_EN
    assign bus.illegal_out  = head_rec.illegal;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, decode fields, fill/full, enq+deq, flush, pause.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam logic [31:0] WAddi = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] WBeq  = 32'hFE00_0EE3; // beq x0,x0,-4
    localparam logic [31:0] WLui  = 32'h1234_52B7; // lui x5,0x12345
    localparam logic [31:0] WSub  = 32'h4020_81B3; // sub x3,x1,x2
    localparam logic [31:0] WSrai = 32'h4032_5213; // srai x4,x4,3

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    logic flush;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    decode_queue_if #(.DEPTH(4), .PC_WIDTH(32)) bus ();

    decode_queue #(.DEPTH(4), .PC_WIDTH(32)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.instr_in = w;
        bus.pc_in    = pc;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input instr_id_e id, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] pc);
        check({tag, ".id"},  64'(bus.instr_id_out), 64'(id));
        check({tag, ".imm"}, 64'(bus.imm_out), 64'(imm));
        check({tag, ".rs1"}, 64'(bus.rs1_out), 64'(rs1));
        check({tag, ".rs2"}, 64'(bus.rs2_out), 64'(rs2));
        check({tag, ".rd"},  64'(bus.rd_out), 64'(rd));
        check({tag, ".pc"},  64'(bus.pc_out), 64'(pc));
    endtask

    task automatic check_flags(input string tag, input logic [2:0] cnt, input logic ov,
                               input logic ir);
        check({tag, ".count"},     64'(bus.count_out), 64'(cnt));
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
        check({tag, ".in_ready"},  64'(bus.in_ready), 64'(ir));
    endtask

    initial begin
        rst_n        = 1'b0;
        rdy          = 1'b1;
        flush        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr_in  = '0;
        bus.pc_in     = '0;
        bus.out_ready = 1'b0;
        #12;
        check_flags("reset", 3'd0, 1'b0, 1'b1);
        check_head("reset", IdZero, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0);
        rst_n = 1'b1;
        step();

        // Single ADDI, one-cycle latency to head.
        push(WAddi, 32'h100);
        check_flags("addi", 3'd1, 1'b1, 1'b1);
        check_head("addi", IdAddi, 32'h5, 5'd0, 5'd0, 5'd1, 32'h100);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_flags("drain", 3'd0, 1'b0, 1'b1);

        // Fill to DEPTH, then a fifth offer must be refused.
        push(WBeq, 32'h200);
        push(WLui, 32'h204);
        push(WSub, 32'h208);
        push(WSrai, 32'h20C);
        check_flags("full", 3'd4, 1'b1, 1'b0);
        push(WAddi, 32'h2FC);
        check_flags("fifth", 3'd4, 1'b1, 1'b0);
        check_head("beq", IdBeq, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd0, 32'h200);

        // Full: enq+deq only drains; next cycle enq+deq keeps occupancy.
        bus.in_valid  = 1'b1;
        bus.instr_in  = WAddi;
        bus.pc_in     = 32'h300;
        bus.out_ready = 1'b1;
        step();
        check_flags("full_ed", 3'd3, 1'b1, 1'b1);
        check_head("lui", IdLui, 32'h1234_5000, 5'd0, 5'd0, 5'd5, 32'h204);
        step();
        bus.in_valid = 1'b0;
        check_flags("ed3", 3'd3, 1'b1, 1'b1);
        check_head("sub", IdSub, 32'h0, 5'd1, 5'd2, 5'd3, 32'h208);
        step();
        check_head("srai", IdSrai, 32'h3, 5'd4, 5'd0, 5'd4, 32'h20C);
        step();
        bus.out_ready = 1'b0;
        check_flags("deq1", 3'd1, 1'b1, 1'b1);
        check_head("addi2", IdAddi, 32'h5, 5'd0, 5'd0, 5'd1, 32'h300);

        // Flush with a concurrent offer: everything dropped.
        push(WAddi, 32'h400);
        check("pre_flush.count", 64'(bus.count_out), 64'd2);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr_in = WSub;
        bus.pc_in    = 32'h500;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check_flags("flush", 3'd0, 1'b0, 1'b1);
        push(WLui, 32'h600);
        check_flags("post_flush", 3'd1, 1'b1, 1'b1);
        check_head("post_flush", IdLui, 32'h1234_5000, 5'd0, 5'd0, 5'd5, 32'h600);

        // Pause: no state change, flush ignored.
        rdy           = 1'b0;
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr_in  = WBeq;
        bus.pc_in     = 32'h700;
        bus.out_ready = 1'b1;
        step();
        check_flags("pause", 3'd1, 1'b1, 1'b1);
        check("pause.pc", 64'(bus.pc_out), 64'h600);
        rdy           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Asynchronous reset with three entries queued.
        push(WSub, 32'h610);
        push(WSrai, 32'h614);
        check("pre_rst.count", 64'(bus.count_out), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("mid_rst", 3'd0, 1'b0, 1'b1);
        check_head("mid_rst", IdZero, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0);
        #1;
        rst_n = 1'b1;
        step();

        // All-zero word matches no op.
        push(32'h0, 32'h800);
        check("zero_word.id", 64'(bus.instr_id_out), 64'(IdZero));
        check("zero_word.pc", 64'(bus.pc_out), 64'h800);
`ifdef ILLEGAL_INSTR_EN
        check("zero_word.illegal", 64'(bus.illegal_out), 64'd1);
        bus.out_ready = 1'b1;
        push(WAddi, 32'h804);
        bus.out_ready = 1'b0;
        check("addi.illegal", 64'(bus.illegal_out), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
